// File: rtl/fetch_unit.sv
// LC-3b instruction fetch stage: owns the PC, runs the imem read handshake and
// drives the FD pipeline register, with buffering for stalls and stale-response discard.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_fd,
  input  logic        reset_fd,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic [15:0] fd_ir,
  output logic [15:0] fd_pc,
  output logic        fd_valid,
  output logic        fetch_stall
);

  // state   | meaning
  // FETCH   | read outstanding at pc; response delivered or buffered
  // HOLD    | response parked in ir_buf while decode is stalled
  // DISCARD | read at stale_addr still outstanding; its data is dropped
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] ir_buf, ir_buf_next;
  logic [15:0] stale_addr, stale_addr_next;
  logic [15:0] fd_ir_next, fd_pc_next;
  logic        fd_valid_next;

  logic [15:0] pc_inc;
  logic [15:0] target_pc;
  logic        deliver;
  logic [15:0] deliver_ir;

  assign pc_inc    = pc + 16'd2;
  assign target_pc = {redirect_pc[15:1], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      ir_buf     <= 16'h0000;
      stale_addr <= 16'h0000;
      fd_ir      <= NOP_INSTR;
      fd_pc      <= 16'h0000;
      fd_valid   <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ir_buf     <= ir_buf_next;
      stale_addr <= stale_addr_next;
      fd_ir      <= fd_ir_next;
      fd_pc      <= fd_pc_next;
      fd_valid   <= fd_valid_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    ir_buf_next     = ir_buf;
    stale_addr_next = stale_addr;
    deliver         = 1'b0;
    deliver_ir      = NOP_INSTR;

    case (state)
      FETCH: begin
        if (imem_resp) begin
          if (redirect) begin
            pc_next = target_pc;
          end else if (load_fd) begin
            deliver    = 1'b1;
            deliver_ir = imem_rdata;
            pc_next    = pc_inc;
          end else begin
            ir_buf_next = imem_rdata;
            state_next  = HOLD;
          end
        end else if (redirect) begin
          // the read already issued at pc must complete before a new one starts
          pc_next         = target_pc;
          stale_addr_next = pc;
          state_next      = DISCARD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target_pc;
          state_next = FETCH;
        end else if (load_fd) begin
          deliver    = 1'b1;
          deliver_ir = ir_buf;
          pc_next    = pc_inc;
          state_next = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) begin
          pc_next = target_pc;
        end
        if (imem_resp) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Flush always bubbles; an advance without a real instruction also bubbles
  // so a valid instruction is never presented to decode twice.
  always_comb begin
    fd_ir_next    = fd_ir;
    fd_pc_next    = fd_pc;
    fd_valid_next = fd_valid;
    if (reset_fd) begin
      fd_ir_next    = NOP_INSTR;
      fd_valid_next = 1'b0;
    end else if (load_fd) begin
      if (deliver) begin
        fd_ir_next    = deliver_ir;
        fd_pc_next    = pc_inc;
        fd_valid_next = 1'b1;
      end else begin
        fd_ir_next    = NOP_INSTR;
        fd_valid_next = 1'b0;
      end
    end
  end

  always_comb begin
    imem_read    = 1'b0;
    imem_address = pc;
    fetch_stall  = 1'b0;
    case (state)
      FETCH: begin
        imem_read   = 1'b1;
        fetch_stall = ~imem_resp;
      end
      DISCARD: begin
        imem_read    = 1'b1;
        imem_address = stale_addr;
        fetch_stall  = 1'b1;
      end
      default: begin
        imem_read = 1'b0;
      end
    endcase
    if (reset) begin
      imem_read = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/hold, stale discard,
// flush with redirect, PC wrap and asynchronous reset during a discard.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        load_fd;
  logic        reset_fd;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic [15:0] fd_ir;
  logic [15:0] fd_pc;
  logic        fd_valid;
  logic        fetch_stall;

  int passed;
  int failed;
  int total;

  fetch_unit #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_fd     (load_fd),
    .reset_fd    (reset_fd),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_read   (imem_read),
    .imem_address(imem_address),
    .imem_resp   (imem_resp),
    .imem_rdata  (imem_rdata),
    .fd_ir       (fd_ir),
    .fd_pc       (fd_pc),
    .fd_valid    (fd_valid),
    .fetch_stall (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    reset       = 1'b1;
    load_fd     = 1'b0;
    reset_fd    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_resp   = 1'b0;
    imem_rdata  = 16'h0000;
    #1;
    chk("rst_imem_read", {15'd0, imem_read}, 16'd0);
    chk("rst_fd_valid", {15'd0, fd_valid}, 16'd0);
    chk("rst_fd_ir", fd_ir, 16'h0000);
    chk("rst_fd_pc", fd_pc, 16'h0000);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("first_read", {15'd0, imem_read}, 16'd1);
    chk("first_addr", imem_address, 16'h0000);

    // same-cycle memory, no stalls
    load_fd    = 1'b1;
    imem_resp  = 1'b1;
    imem_rdata = 16'hA000;
    #1;
    chk("seq_stall0", {15'd0, fetch_stall}, 16'd0);
    tick();
    chk("seq0_ir", fd_ir, 16'hA000);
    chk("seq0_pc", fd_pc, 16'h0002);
    chk("seq0_valid", {15'd0, fd_valid}, 16'd1);
    chk("seq0_addr", imem_address, 16'h0002);
    imem_rdata = 16'hA002;
    tick();
    chk("seq1_ir", fd_ir, 16'hA002);
    chk("seq1_pc", fd_pc, 16'h0004);
    chk("seq1_addr", imem_address, 16'h0004);

    // stall three cycles while the response for 0x0004 returns
    load_fd    = 1'b0;
    imem_rdata = 16'h1234;
    tick();
    imem_resp  = 1'b0;
    imem_rdata = 16'h0000;
    #1;
    chk("hold_read", {15'd0, imem_read}, 16'd0);
    chk("hold_stall", {15'd0, fetch_stall}, 16'd0);
    chk("hold_fd_ir", fd_ir, 16'hA002);
    tick();
    tick();
    chk("hold3_read", {15'd0, imem_read}, 16'd0);
    load_fd = 1'b1;
    tick();
    chk("rel_ir", fd_ir, 16'h1234);
    chk("rel_pc", fd_pc, 16'h0006);
    chk("rel_valid", {15'd0, fd_valid}, 16'd1);
    chk("rel_addr", imem_address, 16'h0006);
    chk("rel_read", {15'd0, imem_read}, 16'd1);

    // two-cycle memory, redirect during the wait cycle
    #1;
    chk("wait_stall", {15'd0, fetch_stall}, 16'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h0400;
    tick();
    redirect = 1'b0;
    chk("disc_valid", {15'd0, fd_valid}, 16'd0);
    chk("disc_ir", fd_ir, 16'h0000);
    chk("disc_fd_pc", fd_pc, 16'h0006);
    chk("disc_addr", imem_address, 16'h0006);
    chk("disc_read", {15'd0, imem_read}, 16'd1);
    chk("disc_stall", {15'd0, fetch_stall}, 16'd1);
    imem_resp  = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    imem_resp = 1'b0;
    #1;
    chk("drop_valid", {15'd0, fd_valid}, 16'd0);
    chk("drop_ir", fd_ir, 16'h0000);
    chk("new_addr", imem_address, 16'h0400);
    chk("new_stall", {15'd0, fetch_stall}, 16'd1);
    imem_resp  = 1'b1;
    imem_rdata = 16'h5555;
    tick();
    chk("tgt_ir", fd_ir, 16'h5555);
    chk("tgt_pc", fd_pc, 16'h0402);
    chk("tgt_valid", {15'd0, fd_valid}, 16'd1);
    chk("tgt_addr", imem_address, 16'h0402);

    // flush with redirect while a response is present
    imem_rdata  = 16'h7777;
    reset_fd    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    reset_fd = 1'b0;
    redirect = 1'b0;
    chk("flush_valid", {15'd0, fd_valid}, 16'd0);
    chk("flush_ir", fd_ir, 16'h0000);
    chk("flush_fd_pc", fd_pc, 16'h0402);
    chk("flush_addr", imem_address, 16'h0100);

    // redirect to 0xFFFF (bit 0 cleared) and wrap
    imem_rdata  = 16'h9999;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    chk("wrap_bubble", {15'd0, fd_valid}, 16'd0);
    chk("wrap_addr0", imem_address, 16'hFFFE);
    imem_rdata = 16'hBEEF;
    tick();
    chk("wrap_ir", fd_ir, 16'hBEEF);
    chk("wrap_pc", fd_pc, 16'h0000);
    chk("wrap_addr1", imem_address, 16'h0000);

    // async reset while in DISCARD, FD holding a valid instruction
    imem_resp   = 1'b0;
    load_fd     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    chk("pre_addr", imem_address, 16'h0000);
    chk("pre_stall", {15'd0, fetch_stall}, 16'd1);
    chk("pre_valid", {15'd0, fd_valid}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_read", {15'd0, imem_read}, 16'd0);
    chk("arst_valid", {15'd0, fd_valid}, 16'd0);
    chk("arst_ir", fd_ir, 16'h0000);
    chk("arst_fd_pc", fd_pc, 16'h0000);
    tick();
    reset = 1'b0;
    #1;
    chk("post_read", {15'd0, imem_read}, 16'd1);
    chk("post_addr", imem_address, 16'h0000);
    chk("post_stall", {15'd0, fetch_stall}, 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
